apb_master_arbiter: RTL and testbench

- Two-requester APB master that shares the single APB slave (4-bit address, 32-bit data) between two on-chip requesters.
- Round-robin arbitration between requesters; the selected request is sequenced through the APB SETUP and ACCESS phases.
- Honours Pready wait states and aborts a stalled transfer with an error after a programmable timeout.
- Returns read data and completion status to the requester that owns the transfer.

---
 rtl/apb_master_arbiter.sv | 123 ++++++++++++
 tb/tb_apb_master_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/apb_master_arbiter.sv
// Two-requester APB master: round-robin arbitration, SETUP/ACCESS sequencing,
// Pready wait states with timeout abort, and per-requester completion reporting.
module apb_master_arbiter #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              Presetn,
    input  logic              r0_valid,
    input  logic              r0_write,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_ready,
    output logic              r0_resp_valid,
    output logic              r0_resp_err,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_valid,
    input  logic              r1_write,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_ready,
    output logic              r1_resp_valid,
    output logic              r1_resp_err,
    output logic [DATA_W-1:0] r1_rdata,
    output logic [ADDR_W-1:0] Paddr,
    output logic              Psel,
    output logic              Penable,
    output logic              Pwrite,
    output logic [DATA_W-1:0] Pwdata,
    input  logic              Pready,
    input  logic [DATA_W-1:0] Prdata
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                  state, state_nxt;
    logic                    last_gnt;
    logic                    owner;
    logic [7:0]              wcnt;
    logic [1:0]              gnt;
    logic                    done, abort, fin;
    logic [1:0]              rsp_vld, rsp_err;
    logic [1:0][DATA_W-1:0]  rsp_data;

    // The requester that did not win last time takes a tie.
    assign gnt[0] = r0_valid && (!r1_valid || last_gnt);
    assign gnt[1] = r1_valid && (!r0_valid || !last_gnt);

    assign done  = (state == ACCESS) && Pready;
    assign abort = (state == ACCESS) && !Pready && (wcnt == 8'(TIMEOUT - 1));
    assign fin   = done || abort;

    always_ff @(posedge PCLK or negedge Presetn) begin
        if (!Presetn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|gnt) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (fin) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        Psel     = (state == SETUP) || (state == ACCESS);
        Penable  = (state == ACCESS);
        r0_ready = (state == IDLE) && gnt[0];
        r1_ready = (state == IDLE) && gnt[1];
    end

    always_ff @(posedge PCLK or negedge Presetn) begin
        if (!Presetn) begin
            Paddr    <= '0;
            Pwrite   <= 1'b0;
            Pwdata   <= '0;
            owner    <= 1'b0;
            last_gnt <= 1'b1;
            wcnt     <= '0;
        end else begin
            if (state == IDLE && |gnt) begin
                Paddr    <= gnt[1] ? r1_addr  : r0_addr;
                Pwrite   <= gnt[1] ? r1_write : r0_write;
                Pwdata   <= gnt[1] ? r1_wdata : r0_wdata;
                owner    <= gnt[1];
                last_gnt <= gnt[1];
            end
            if (state == SETUP)
                wcnt <= '0;
            else if (state == ACCESS && !Pready && !abort)
                wcnt <= wcnt + 8'd1;
        end
    end

    // Completion status only reaches the owner; the other lane keeps its last result.
    always_ff @(posedge PCLK or negedge Presetn) begin
        if (!Presetn) begin
            rsp_vld  <= '0;
            rsp_err  <= '0;
            rsp_data <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                rsp_vld[i] <= fin && (owner == 1'(i));
                if (fin && (owner == 1'(i))) begin
                    rsp_err[i]  <= abort;
                    rsp_data[i] <= (done && !Pwrite) ? Prdata : '0;
                end
            end
        end
    end

    assign r0_resp_valid = rsp_vld[0];
    assign r0_resp_err   = rsp_err[0];
    assign r0_rdata      = rsp_data[0];
    assign r1_resp_valid = rsp_vld[1];
    assign r1_resp_err   = rsp_err[1];
    assign r1_rdata      = rsp_data[1];

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter: write, waited read, ties, timeout,
// asynchronous reset mid-transfer, and a request held across a busy period.
module tb_apb_master_arbiter;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;

    logic              PCLK = 1'b0;
    logic              Presetn;
    logic              r0_valid, r0_write, r1_valid, r1_write;
    logic [ADDR_W-1:0] r0_addr, r1_addr;
    logic [DATA_W-1:0] r0_wdata, r1_wdata;
    logic              r0_ready, r0_resp_valid, r0_resp_err;
    logic              r1_ready, r1_resp_valid, r1_resp_err;
    logic [DATA_W-1:0] r0_rdata, r1_rdata;
    logic [ADDR_W-1:0] Paddr;
    logic              Psel, Penable, Pwrite, Pready;
    logic [DATA_W-1:0] Pwdata, Prdata;

    int n_chk = 0;
    int n_err = 0;

    apb_master_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(16)) dut (
        .PCLK(PCLK), .Presetn(Presetn),
        .r0_valid(r0_valid), .r0_write(r0_write), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_ready(r0_ready), .r0_resp_valid(r0_resp_valid), .r0_resp_err(r0_resp_err),
        .r0_rdata(r0_rdata),
        .r1_valid(r1_valid), .r1_write(r1_write), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_ready(r1_ready), .r1_resp_valid(r1_resp_valid), .r1_resp_err(r1_resp_err),
        .r1_rdata(r1_rdata),
        .Paddr(Paddr), .Psel(Psel), .Penable(Penable), .Pwrite(Pwrite), .Pwdata(Pwdata),
        .Pready(Pready), .Prdata(Prdata)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    int en, n;

    initial begin
        Presetn = 1'b0;
        {r0_valid, r0_write, r1_valid, r1_write} = '0;
        r0_addr = '0; r1_addr = '0; r0_wdata = '0; r1_wdata = '0;
        Pready = 1'b1; Prdata = '0;
        step(); step();
        chk("rst_psel", Psel, 0);
        chk("rst_penable", Penable, 0);
        chk("rst_paddr", Paddr, 0);
        chk("rst_resp", {r0_resp_valid, r1_resp_valid, r0_resp_err, r1_resp_err}, 0);
        chk("rst_ready", {r0_ready, r1_ready}, 0);
        Presetn = 1'b1;
        step();

        // single write from r0, Pready tied high
        r0_valid = 1; r0_write = 1; r0_addr = 4'h3; r0_wdata = 32'h0000_00A5;
        #1;
        chk("wr_ready", {r0_ready, r1_ready}, 2'b10);
        chk("wr_idle_psel", Psel, 0);
        step(); r0_valid = 0; #1;
        chk("wr_setup", {Psel, Penable}, 2'b10);
        chk("wr_paddr", Paddr, 3);
        chk("wr_pwrite", Pwrite, 1);
        chk("wr_pwdata", Pwdata, 32'hA5);
        chk("wr_ready_lo", r0_ready, 0);
        step();
        chk("wr_access", {Psel, Penable}, 2'b11);
        step();
        chk("wr_resp", {r0_resp_valid, r0_resp_err}, 2'b10);
        chk("wr_rdata", r0_rdata, 0);
        chk("wr_psel_lo", Psel, 0);
        chk("wr_paddr_hold", Paddr, 3);
        step();
        chk("wr_pulse", r0_resp_valid, 0);

        // read from r1 with two wait states
        r1_valid = 1; r1_write = 0; r1_addr = 4'h7; Pready = 0; Prdata = 32'hDEAD_BEEF;
        #1;
        chk("rd_ready", {r0_ready, r1_ready}, 2'b01);
        step(); r1_valid = 0;
        en = 0; n = 0;
        while (!r1_resp_valid && n < 50) begin
            if (Penable) en++;
            Pready = (en >= 3);
            step(); n++;
        end
        chk("rd_penable_cycles", en, 3);
        chk("rd_resp", {r1_resp_valid, r1_resp_err}, 2'b10);
        chk("rd_rdata", r1_rdata, 32'hDEAD_BEEF);
        chk("rd_no_r0", r0_resp_valid, 0);
        step();
        chk("rd_pulse", r1_resp_valid, 0);
        chk("rd_hold", r1_rdata, 32'hDEAD_BEEF);

        // ties after reset: r0, r1, r0
        Presetn = 0; step(); Presetn = 1; step();
        Pready = 1;
        r0_valid = 1; r0_write = 1; r0_addr = 4'h1; r0_wdata = 32'h11;
        r1_valid = 1; r1_write = 1; r1_addr = 4'h2; r1_wdata = 32'h22;
        #1;
        chk("tie1", {r0_ready, r1_ready}, 2'b10);
        step(); r0_valid = 0; #1;
        chk("tie1_paddr", Paddr, 1);
        step(); step();
        chk("tie1_resp", r0_resp_valid, 1);
        r0_valid = 1;
        #1;
        chk("tie2", {r0_ready, r1_ready}, 2'b01);
        step(); r1_valid = 0; #1;
        chk("tie2_paddr", Paddr, 2);
        step(); step();
        chk("tie2_resp", {r0_resp_valid, r1_resp_valid}, 2'b01);
        r1_valid = 1;
        #1;
        chk("tie3", {r0_ready, r1_ready}, 2'b10);
        step(); r0_valid = 0; r1_valid = 0;
        step(); step(); step();

        // timeout with Pready held low
        r0_valid = 1; r0_write = 0; r0_addr = 4'h5; Pready = 0; Prdata = 32'h1234_5678;
        step(); r0_valid = 0;
        en = 0; n = 0;
        while (!r0_resp_valid && n < 100) begin
            if (Penable) en++;
            step(); n++;
        end
        chk("to_cycles", en, 16);
        chk("to_resp", {r0_resp_valid, r0_resp_err}, 2'b11);
        chk("to_rdata", r0_rdata, 0);
        chk("to_idle", {Psel, Penable}, 2'b00);
        step();

        // reset during the second ACCESS cycle
        r0_valid = 1; r0_write = 1; r0_addr = 4'hC; r0_wdata = 32'h77;
        step(); r0_valid = 0;
        step(); step();
        chk("mr_access", {Psel, Penable, 4'(Paddr)}, 6'b11_1100);
        Presetn = 0;
        #1;
        chk("mr_async", {Psel, Penable, 4'(Paddr)}, 6'b0);
        step();
        chk("mr_noresp", {r0_resp_valid, r1_resp_valid}, 0);
        Presetn = 1; step();
        chk("mr_noresp2", {r0_resp_valid, r1_resp_valid}, 0);
        r0_valid = 1; r0_addr = 4'h4; r1_valid = 1; r1_write = 0; r1_addr = 4'h9;
        Pready = 0;
        #1;
        chk("mr_tie", {r0_ready, r1_ready}, 2'b10);

        // r1 held across r0's transfer
        step(); r0_valid = 0; #1;
        chk("busy_setup", r1_ready, 0);
        step();
        chk("busy_access", r1_ready, 0);
        Pready = 1;
        step();
        chk("busy_idle", {r0_resp_valid, r1_ready}, 2'b11);
        step(); r1_valid = 0; #1;
        chk("busy_r1_paddr", Paddr, 9);
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
